// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared constants and enumerations for the ULA accumulator
//               sequencer: datapath width, opcode encoding, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

   localparam int C_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_LOAD = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_AND  = 3'b011,
      OP_OR   = 3'b100,
      OP_MUL  = 3'b101,
      OP_CLR  = 3'b110,
      OP_RSVD = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : ula_mul_unit
// Description : Shift-add multiplier sequencing state. Holds multiplicand M,
//               multiplier Q, partial product P and the iteration counter, and
//               presents the operands the shared ULA adder needs each cycle.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_start          - load M=i_acc, Q=i_b, P=0, counter=0
//               i_run            - perform one iteration this cycle
//               i_acc, i_b       - initial multiplicand / multiplier
//               i_sum            - ULA adder sum (P + partial term)
//               o_alu_a, o_alu_b - adder operands (0 when not running)
//               o_done           - this cycle is the 8th iteration
// Revision    : 1.0 - initial release
// ============================================================================
module ula_mul_unit
   import ula_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic               i_run,
   input  logic [C_WIDTH-1:0] i_acc,
   input  logic [C_WIDTH-1:0] i_b,
   input  logic [C_WIDTH-1:0] i_sum,
   output logic [C_WIDTH-1:0] o_alu_a,
   output logic [C_WIDTH-1:0] o_alu_b,
   output logic               o_done
);

   logic [C_WIDTH-1:0] m_q, m_d;
   logic [C_WIDTH-1:0] q_q, q_d;
   logic [C_WIDTH-1:0] p_q, p_d;
   logic [2:0]         cnt_q, cnt_d;

   always_comb begin
      m_d   = m_q;
      q_d   = q_q;
      p_d   = p_q;
      cnt_d = cnt_q;
      if (i_start) begin
         m_d   = i_acc;
         q_d   = i_b;
         p_d   = '0;
         cnt_d = 3'd0;
      end else if (i_run) begin
         p_d   = i_sum;
         m_d   = m_q << 1;
         q_d   = q_q >> 1;
         cnt_d = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q   <= '0;
         q_q   <= '0;
         p_q   <= '0;
         cnt_q <= 3'd0;
      end else begin
         m_q   <= m_d;
         q_q   <= q_d;
         p_q   <= p_d;
         cnt_q <= cnt_d;
      end
   end

   // Partial term is M when the current multiplier LSB is set, else zero.
   assign o_alu_a = i_run ? p_q : '0;
   assign o_alu_b = (i_run && q_q[0]) ? m_q : '0;
   assign o_done  = i_run && (cnt_q == 3'd7);

endmodule : ula_mul_unit
`default_nettype wire

// File: rtl/ula_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ula_acc_sequencer
// Description : Accumulator command sequencer in front of the 8-bit ULA.
//               Accepts one command per valid/ready handshake, drives the ULA
//               operands, captures results into ACC with Z/C/ERR flags, and
//               sequences MUL as 8 shift-add iterations through the adder.
// Ports       : CLK, RST                      - clock, sync active-high reset
//               CMD_VALID/READY/OP/DATA       - command handshake
//               RSP_VALID, RSP_DATA           - one-cycle result pulse
//               FLAG_Z, FLAG_C, FLAG_ERR      - status of last command
//               ALU_A, ALU_B, ALU_CIN         - ULA inputs
//               ALU_SUM, ALU_COUT, ALU_AND,
//               ALU_OR                        - ULA results
// Revision    : 1.0 - initial release
// ============================================================================
module ula_acc_sequencer
   import ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [2:0]       CMD_OP,
   input  logic [WIDTH-1:0] CMD_DATA,
   output logic             RSP_VALID,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             FLAG_Z,
   output logic             FLAG_C,
   output logic             FLAG_ERR,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic             ALU_CIN,
   input  logic [WIDTH-1:0] ALU_SUM,
   input  logic             ALU_COUT,
   input  logic [WIDTH-1:0] ALU_AND,
   input  logic [WIDTH-1:0] ALU_OR
);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               z_q, z_d;
   logic               c_q, c_d;
   logic               err_q, err_d;

   logic               mul_start;
   logic               mul_run;
   logic               mul_done;
   logic [WIDTH-1:0]   mul_a;
   logic [WIDTH-1:0]   mul_b;

   ula_mul_unit u_mul (
      .clk     (CLK),
      .rst     (RST),
      .i_start (mul_start),
      .i_run   (mul_run),
      .i_acc   (acc_q),
      .i_b     (CMD_DATA),
      .i_sum   (ALU_SUM),
      .o_alu_a (mul_a),
      .o_alu_b (mul_b),
      .o_done  (mul_done)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      b_d       = b_q;
      acc_d     = acc_q;
      z_d       = z_q;
      c_d       = c_q;
      err_d     = err_q;
      mul_start = 1'b0;
      mul_run   = 1'b0;
      ALU_A     = '0;
      ALU_B     = '0;
      ALU_CIN   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID && CMD_READY) begin
               op_d      = op_e'(CMD_OP);
               b_d       = CMD_DATA;
               mul_start = (op_e'(CMD_OP) == OP_MUL);
               state_d   = (op_e'(CMD_OP) == OP_MUL) ? ST_MUL : ST_EXEC;
            end
         end

         ST_EXEC: begin
            // SUB is ACC + ~B + 1, so COUT=1 means no borrow.
            ALU_A   = acc_q;
            ALU_B   = (op_q == OP_SUB) ? ~b_q : b_q;
            ALU_CIN = (op_q == OP_SUB);
            c_d     = 1'b0;
            err_d   = 1'b0;
            case (op_q)
               OP_LOAD: acc_d = b_q;
               OP_ADD,
               OP_SUB: begin
                  acc_d = ALU_SUM;
                  c_d   = ALU_COUT;
               end
               OP_AND:  acc_d = ALU_AND;
               OP_OR:   acc_d = ALU_OR;
               OP_CLR:  acc_d = '0;
               OP_RSVD: err_d = 1'b1;
               default: acc_d = acc_q;
            endcase
            z_d     = (acc_d == '0);
            state_d = ST_DONE;
         end

         ST_MUL: begin
            mul_run = 1'b1;
            ALU_A   = mul_a;
            ALU_B   = mul_b;
            if (mul_done) begin
               acc_d   = ALU_SUM;
               z_d     = (ALU_SUM == '0);
               c_d     = 1'b0;
               err_d   = 1'b0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         b_q     <= '0;
         acc_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         c_q     <= c_d;
         err_q   <= err_d;
      end
   end

   // Reset aborts immediately: no handshake and no response while RST is high.
   assign CMD_READY = (state_q == ST_IDLE) && !RST;
   assign RSP_VALID = (state_q == ST_DONE) && !RST;
   assign RSP_DATA  = acc_q;
   assign FLAG_Z    = z_q;
   assign FLAG_C    = c_q;
   assign FLAG_ERR  = err_q;

endmodule : ula_acc_sequencer
`default_nettype wire

// File: doc/ula_acc_sequencer.md
# ula_acc_sequencer

Accumulator-based command sequencer that sits directly upstream of the 8-bit ULA datapath (ripple adder, AND and OR arrays). It accepts one command at a time over a valid/ready handshake and drives the ULA operand and carry-in inputs. It captures the ULA outputs into an 8-bit accumulator with zero, carry and error flags. Multiplication is sequenced as 8 shift-add iterations through the same adder.

## Interface
- WIDTH, 8: datapath width; only 8 is supported.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  3  opcode.
- CMD_DATA  in  8  operand B.
- RSP_VALID  out  1  one-cycle pulse; result available.
- RSP_DATA  out  8  accumulator value.
- FLAG_Z  out  1  accumulator == 0 after the last command.
- FLAG_C  out  1  carry from the last ADD/SUB.
- FLAG_ERR  out  1  last command had a reserved opcode.
- ALU_A  out  8  operand A to the ULA.
- ALU_B  out  8  operand B to the ULA.
- ALU_CIN  out  1  adder carry-in.
- ALU_SUM  in  8  adder sum.
- ALU_COUT  in  1  adder carry-out.
- ALU_AND  in  8  AND-array result.
- ALU_OR  in  8  OR-array result.

## Operation
- Opcodes:
  - 000 LOAD: ACC=B.
  - 001 ADD: ACC=ACC+B, CIN=0.
  - 010 SUB: ACC=ACC+~B with CIN=1. C=COUT, so C=1 means no borrow.
  - 011 AND: ACC=ALU_AND.
  - 100 OR: ACC=ALU_OR.
  - 101 MUL: ACC = low 8 bits of ACC*B.
  - 110 CLR: ACC=0.
  - 111 reserved: ACC unchanged, ERR=1.
- Flags:
  - Z is updated on every completed command.
  - C is updated only by ADD/SUB and cleared by all other opcodes.
  - ERR is set only by opcode 111 and cleared by any valid opcode.
- FSM states:
  - IDLE: CMD_READY=1. When CMD_VALID && CMD_READY, latch OP and B and go to EXEC, or to MUL if OP=101.
  - EXEC: drive ALU_A=ACC, ALU_B=B or ~B, ALU_CIN. At the end of the cycle write ACC and flags, then go to DONE.
  - MUL: registers M=ACC (multiplicand), Q=B, P=0 and a 3-bit counter.
    - Each cycle drive ALU_A=P, ALU_B = Q[0] ? M : 0, ALU_CIN=0.
    - Register P=ALU_SUM, M=M<<1, Q=Q>>1.
    - After 8 iterations write ACC=P and go to DONE.
  - DONE: RSP_VALID=1, RSP_DATA=ACC; go to IDLE.
- Outside EXEC and MUL, ALU_A/ALU_B/ALU_CIN are driven to 0.
- There is no response backpressure; the consumer must take RSP_DATA in the pulse cycle.
- Arithmetic is mod 256. MUL overflow bits are discarded silently.

## Timing
- Reset values:
  - ACC, FLAG_Z, FLAG_C, FLAG_ERR, RSP_VALID, RSP_DATA = 0.
  - State = IDLE.
  - CMD_READY=0 while RST is high.
- Cycle numbering: handshake in cycle 0.
  - Single-cycle ops: EXEC in cycle 1, RSP_VALID in cycle 2, CMD_READY high again in cycle 3.
  - MUL: iterations in cycles 1-8, RSP_VALID in cycle 9, ready in cycle 10.
- Flags and RSP_DATA change on the edge that enters DONE. They hold until the next command completes.
- CMD_OP and CMD_DATA are sampled only at the handshake and may change afterwards.
- CMD_VALID outside IDLE is ignored. The command is not lost, because it is not accepted until ready.
- RST at any cycle, including mid-MUL or in DONE:
  - Abort the command and return to reset values on the next edge.
  - No RSP_VALID is produced for the aborted command.
  - CMD_READY is 1 in the first cycle after RST deasserts.

## Structure
- Package ula_pkg: WIDTH constant, opcode enum (OP_LOAD..OP_RSVD), FSM state enum.
- One sub-module is natural: ula_mul_unit, holding the M/Q/P registers and the iteration counter. It exposes the ALU_A/ALU_B mux values and a done strobe.
- The bench top instantiates the sequencer wired bit-by-bit to the existing structural 8-bit adder, AND and OR modules.

## Test plan
- Add with carry: LOAD 0x05, then ADD 0xFB → RSP_DATA=0x00, Z=1, C=1. RSP_VALID exactly 2 cycles after each handshake.
- Subtract with borrow: LOAD 0x10, then SUB 0x20 → 0xF0, C=0, Z=0. Then SUB 0x70 → 0x80, C=1.
- Logic ops: LOAD 0xF0, AND 0x3C → 0x30, C=0. Then OR 0x0F → 0x3F. Each bit is checked individually.
- Multiply: LOAD 0x0C, MUL 0x0D → 0x9C in cycle 9, CMD_READY low in cycles 1-9. Then MUL 0x20 → 0x80, with overflow discarded.
- Reserved and idle handling:
  - CMD_OP=111 with ACC=0x42 → ERR=1, RSP_DATA=0x42.
  - CMD_VALID held during EXEC is accepted only at cycle 3.
- Reset mid-MUL: assert RST in cycle 4 of MUL → ACC=0 and all flags 0, no RSP_VALID. CMD_READY=1 in the first cycle after release.
